led_sequencer: RTL

- Parametrised, multi-mode successor to the single-pattern LED flasher. Drives an N-bit LED bank with five selectable patterns: bounce, rotate-left, rotate-right, blink and bar-fill.
- Uses an internal clock-enable tick divider instead of a derived clock, so all logic runs on one clock.
- Supports run-time divider change, enable/hold and single-step, and sits directly between board switches/keys and the LEDR bank.

---
 rtl/led_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/led_sequencer.sv
// Multi-mode LED bank sequencer: bounce, rotate, blink and bar-fill patterns
// advanced by an internal clock-enable divider, with hold and single-step.
module led_sequencer #(
  parameter int N         = 8,
  parameter int DIV_BUS   = 32,
  parameter bit BLINK_ALL = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               step,
  input  logic [2:0]         mode,
  input  logic [DIV_BUS-1:0] div,
  output logic [N-1:0]       out_led,
  output logic               tick,
  output logic               dir
);

  localparam logic [2:0] M_BOUNCE = 3'd0;
  localparam logic [2:0] M_ROTL   = 3'd1;
  localparam logic [2:0] M_ROTR   = 3'd2;
  localparam logic [2:0] M_BLINK  = 3'd3;
  localparam logic [2:0] M_FILL   = 3'd4;

  localparam logic [N-1:0]       ONE_MSB = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]       ONE_LSB = {{(N-1){1'b0}}, 1'b1};
  localparam logic [DIV_BUS-1:0] ONE_DIV = {{(DIV_BUS-1){1'b0}}, 1'b1};

  function automatic logic [N-1:0] alt_pattern();
    logic [N-1:0] a;
    for (int i = 0; i < N; i++) a[i] = ~i[0];
    return a;
  endfunction

  localparam logic [N-1:0] ALT = alt_pattern();

  // Unused codes keep whatever the bank currently shows.
  function automatic logic [N-1:0] start_led(input logic [2:0] m, input logic [N-1:0] cur);
    logic [N-1:0] r;
    case (m)
      M_BOUNCE, M_ROTR: r = ONE_MSB;
      M_ROTL:           r = ONE_LSB;
      M_BLINK:          r = BLINK_ALL ? {N{1'b1}} : ALT;
      M_FILL:           r = '0;
      default:          r = cur;
    endcase
    return r;
  endfunction

  logic [DIV_BUS-1:0] cnt, cnt_nxt, dm1;
  logic [2:0]         mode_q, mode_nxt;
  logic [N-1:0]       led_nxt;
  logic               dir_nxt, tick_nxt;
  logic               adv_div, adv, mode_chg;

  always_comb begin
    dm1      = (div == '0) ? '0 : div - ONE_DIV;
    adv_div  = en && (cnt >= dm1);
    adv      = adv_div || step;
    mode_chg = (mode != mode_q);
    led_nxt  = out_led;
    dir_nxt  = dir;
    tick_nxt = 1'b0;
    cnt_nxt  = cnt;
    mode_nxt = mode_q;
    if (mode_chg) begin
      led_nxt  = start_led(mode, out_led);
      dir_nxt  = (mode == M_FILL);
      cnt_nxt  = '0;
      mode_nxt = mode;
    end else if (adv) begin
      tick_nxt = 1'b1;
      cnt_nxt  = '0;
      case (mode_q)
        M_BOUNCE: begin
          if (!dir) begin
            if (out_led[0]) begin
              dir_nxt = 1'b1;
              led_nxt = out_led << 1;
            end else begin
              led_nxt = out_led >> 1;
            end
          end else begin
            if (out_led[N-1]) begin
              dir_nxt = 1'b0;
              led_nxt = out_led >> 1;
            end else begin
              led_nxt = out_led << 1;
            end
          end
        end
        M_ROTL:  led_nxt = {out_led[N-2:0], out_led[N-1]};
        M_ROTR:  led_nxt = {out_led[0], out_led[N-1:1]};
        M_BLINK: led_nxt = ~out_led;
        M_FILL: begin
          // Fill up from the LSB, then drain by shifting zeros in.
          if (dir) begin
            led_nxt = {out_led[N-2:0], 1'b1};
            if (&led_nxt) dir_nxt = 1'b0;
          end else begin
            led_nxt = out_led << 1;
            if (led_nxt == '0) dir_nxt = 1'b1;
          end
        end
        default: led_nxt = out_led;
      endcase
    end else if (en) begin
      cnt_nxt = cnt + ONE_DIV;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      tick    <= 1'b0;
      mode_q  <= mode;
      out_led <= start_led(mode, out_led);
      dir     <= (mode == M_FILL);
    end else begin
      cnt     <= cnt_nxt;
      tick    <= tick_nxt;
      mode_q  <= mode_nxt;
      out_led <= led_nxt;
      dir     <= dir_nxt;
    end
  end

endmodule
